// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU program-load path: loader state encoding,
// frame sync marker and instruction memory geometry.
package cpu_pkg;

    localparam int         IMEM_DEPTH  = 32;
    localparam int         IMEM_ADDR_W = 5;
    localparam logic [7:0] SYNC_BYTE   = 8'hA5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_LEN = 3'd1,
        LOAD     = 3'd2,
        CHECK    = 3'd3,
        DONE     = 3'd4,
        ERROR    = 3'd5
    } state_t;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// flags the cycle on which the limit is reached.
module loader_timeout #(
    parameter int LIMIT = 100000
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    assign expire = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/uart_program_loader.sv
// Receives a framed program (sync, length, bytes, checksum) from the UART and
// writes it into instruction memory, holding the CPU in reset until it checks out.
module uart_program_loader #(
    parameter int         ADDR_W      = cpu_pkg::IMEM_ADDR_W,
    parameter int         DEPTH       = cpu_pkg::IMEM_DEPTH,
    parameter logic [7:0] SYNC_BYTE   = cpu_pkg::SYNC_BYTE,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [7:0]        Rx_data,
    input  logic              Rx_valid,
    output logic              Imem_we,
    output logic [ADDR_W-1:0] Imem_addr,
    output logic [7:0]        Imem_wdata,
    output logic              Cpu_reset,
    output logic              Load_done,
    output logic              Load_err,
    output logic [2:0]        dbg_state
);

    import cpu_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] len;
    logic [7:0]       csum;
    logic             active;
    logic             expire;
    logic             tmo_clear;
    logic             len_ok;
    logic             last_byte;
    logic             sync_seen;

    assign active    = (state == WAIT_LEN) || (state == LOAD) || (state == CHECK);
    assign len_ok    = (Rx_data != 8'd0) && (int'(Rx_data) <= DEPTH);
    assign last_byte = (count + CNT_W'(1)) == len;
    assign sync_seen = Rx_valid && (Rx_data == SYNC_BYTE);
    // Any received byte or state change restarts the idle window.
    assign tmo_clear = Rx_valid || !active || (next_state != state);
    assign dbg_state = state;

    loader_timeout #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timeout (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .clear  (tmo_clear),
        .enable (active),
        .expire (expire)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A received byte always wins over a timeout expiring in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (sync_seen) next_state = WAIT_LEN;
            WAIT_LEN: begin
                if (Rx_valid)    next_state = len_ok ? LOAD : ERROR;
                else if (expire) next_state = ERROR;
            end
            LOAD: begin
                if (Rx_valid) begin
                    if (last_byte) next_state = CHECK;
                end else if (expire) begin
                    next_state = ERROR;
                end
            end
            CHECK: begin
                if (Rx_valid)    next_state = (Rx_data == csum) ? DONE : ERROR;
                else if (expire) next_state = ERROR;
            end
            DONE:     if (sync_seen) next_state = WAIT_LEN;
            ERROR:    if (sync_seen) next_state = WAIT_LEN;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Imem_we    <= 1'b0;
            Imem_addr  <= '0;
            Imem_wdata <= '0;
            Cpu_reset  <= 1'b1;
            Load_done  <= 1'b0;
            Load_err   <= 1'b0;
            count      <= '0;
            len        <= '0;
            csum       <= '0;
        end else begin
            Imem_we <= 1'b0;
            if (state == WAIT_LEN && Rx_valid) begin
                len   <= Rx_data[CNT_W-1:0];
                count <= '0;
                csum  <= '0;
            end
            if (state == LOAD && Rx_valid) begin
                Imem_we    <= 1'b1;
                Imem_addr  <= count[ADDR_W-1:0];
                Imem_wdata <= Rx_data;
                csum       <= csum + Rx_data;
                count      <= count + CNT_W'(1);
            end
            // Status outputs follow the state being entered so they line up with it.
            Cpu_reset <= (next_state != DONE);
            Load_done <= (next_state == DONE);
            Load_err  <= (next_state == ERROR);
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: frames are pushed byte by byte and
// memory writes are scored against an expected queue.
module tb_uart_program_loader;

    import cpu_pkg::*;

    localparam int TMO = 20;

    logic       Clk;
    logic       Reset_n;
    logic [7:0] Rx_data;
    logic       Rx_valid;
    logic       Imem_we;
    logic [4:0] Imem_addr;
    logic [7:0] Imem_wdata;
    logic       Cpu_reset;
    logic       Load_done;
    logic       Load_err;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];

    uart_program_loader #(
        .TIMEOUT_CYC(TMO)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Rx_data   (Rx_data),
        .Rx_valid  (Rx_valid),
        .Imem_we   (Imem_we),
        .Imem_addr (Imem_addr),
        .Imem_wdata(Imem_wdata),
        .Cpu_reset (Cpu_reset),
        .Load_done (Load_done),
        .Load_err  (Load_err),
        .dbg_state (dbg_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        Rx_data  = b;
        Rx_valid = 1'b1;
        @(negedge Clk);
        Rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic expect_write(input logic [4:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    always @(negedge Clk) begin
        if (Imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", Imem_we, 1'b0);
            end else begin
                check("imem_write", {Imem_addr, Imem_wdata}, exp_q.pop_front());
            end
        end
    end

    initial begin
        Reset_n  = 1'b0;
        Rx_valid = 1'b0;
        Rx_data  = 8'h00;
        idle(3);
        check("rst_cpu_reset", Cpu_reset, 1'b1);
        check("rst_load_done", Load_done, 1'b0);
        check("rst_load_err", Load_err, 1'b0);
        check("rst_we", Imem_we, 1'b0);
        check("rst_addr", Imem_addr, 5'd0);
        check("rst_wdata", Imem_wdata, 8'h00);
        check("rst_state", dbg_state, IDLE);
        Reset_n = 1'b1;
        idle(2);

        send(8'h3C);
        check("idle_stray_state", dbg_state, IDLE);

        // Good frame: 11+22+33 = 66
        expect_write(5'd0, 8'h11);
        expect_write(5'd1, 8'h22);
        expect_write(5'd2, 8'h33);
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        check("good_cpu_held", Cpu_reset, 1'b1);
        send(8'h66);
        check("good_done", Load_done, 1'b1);
        check("good_cpu_run", Cpu_reset, 1'b0);
        check("good_err", Load_err, 1'b0);
        check("good_state", dbg_state, DONE);

        send(8'h12);
        check("done_stray_state", dbg_state, DONE);
        check("done_stray_done", Load_done, 1'b1);

        // Reload from DONE, then illegal length 0
        send(8'hA5);
        check("reload_cpu_reset", Cpu_reset, 1'b1);
        check("reload_done", Load_done, 1'b0);
        check("reload_state", dbg_state, WAIT_LEN);
        send(8'h00);
        check("len0_err", Load_err, 1'b1);
        check("len0_state", dbg_state, ERROR);
        idle(2);

        send(8'hA5);
        check("err_exit_clear", Load_err, 1'b0);
        send(8'h21);
        check("len33_err", Load_err, 1'b1);
        check("len33_cpu", Cpu_reset, 1'b1);
        idle(2);

        // Bad checksum: E1+07 = E8, not 00
        expect_write(5'd0, 8'hE1);
        expect_write(5'd1, 8'h07);
        send(8'hA5); send(8'h02); send(8'hE1); send(8'h07); send(8'h00);
        check("badsum_err", Load_err, 1'b1);
        check("badsum_cpu", Cpu_reset, 1'b1);
        check("badsum_done", Load_done, 1'b0);
        expect_write(5'd0, 8'hFF);
        send(8'hA5); send(8'h01); send(8'hFF); send(8'hFF);
        check("recover_done", Load_done, 1'b1);
        check("recover_err", Load_err, 1'b0);

        // Full-depth frame: bytes 7*i+3, checksum sums to F0
        send(8'hA5); send(8'h20);
        for (int i = 0; i < 32; i++) begin
            expect_write(5'(i), 8'(i * 7 + 3));
            send(8'(i * 7 + 3));
        end
        check("full_state_check", dbg_state, CHECK);
        send(8'hF0);
        check("full_done", Load_done, 1'b1);

        // Timeout expiring after TMO silent cycles
        expect_write(5'd0, 8'h10);
        send(8'hA5); send(8'h02); send(8'h10);
        idle(TMO - 1);
        check("tmo_not_yet", Load_err, 1'b0);
        idle(1);
        check("tmo_err", Load_err, 1'b1);
        check("tmo_state", dbg_state, ERROR);

        // Byte landing on the expiry cycle keeps the frame alive
        expect_write(5'd0, 8'h10);
        expect_write(5'd1, 8'h20);
        send(8'hA5); send(8'h02); send(8'h10);
        idle(TMO - 1);
        send(8'h20);
        check("tmo_race_err", Load_err, 1'b0);
        check("tmo_race_state", dbg_state, CHECK);
        send(8'h30);
        check("tmo_race_done", Load_done, 1'b1);

        // Reset in the middle of a load
        expect_write(5'd0, 8'h01);
        send(8'hA5); send(8'h04); send(8'h01);
        #2 Reset_n = 1'b0;
        #1;
        check("midrst_cpu", Cpu_reset, 1'b1);
        check("midrst_done", Load_done, 1'b0);
        check("midrst_we", Imem_we, 1'b0);
        check("midrst_state", dbg_state, IDLE);
        idle(2);
        Reset_n = 1'b1;
        idle(1);
        expect_write(5'd0, 8'hAA);
        expect_write(5'd1, 8'hBB);
        send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h65);
        check("post_rst_done", Load_done, 1'b1);
        check("post_rst_cpu", Cpu_reset, 1'b0);

        idle(3);
        check("writes_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
